// File: rtl/rf_wb_scheduler_pkg.sv
// rf_wb_scheduler_pkg: shared widths, write-source encoding and load-return entry type
package rf_wb_scheduler_pkg;
  localparam int REG_W = 5;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {WSRC_NONE, WSRC_ALU, WSRC_LD} wsrc_e;
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0] data;
  } ld_ret_t;
endpackage

// File: rtl/rf_wb_scheduler_if.sv
// rf_wb_scheduler_if: issue, ALU writeback, load-return and reg-file write signals; slave = scheduler, master = environment
interface rf_wb_scheduler_if;
  import rf_wb_scheduler_pkg::*;
  logic issue_valid;
  logic [REG_W-1:0] issue_rs1;
  logic [REG_W-1:0] issue_rs2;
  logic [REG_W-1:0] issue_rd;
  logic issue_is_ld;
  logic issue_stall;
  logic alu_wb_valid;
  logic [REG_W-1:0] alu_wb_rd;
  logic [XLEN-1:0] alu_wb_data;
  logic ld_ret_valid;
  logic ld_ret_ready;
  logic [REG_W-1:0] ld_ret_rd;
  logic [XLEN-1:0] ld_ret_data;
  logic rf_we;
  logic [REG_W-1:0] rf_wa;
  logic [XLEN-1:0] rf_wd;
  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_is_ld,
    output alu_wb_valid, alu_wb_rd, alu_wb_data,
    output ld_ret_valid, ld_ret_rd, ld_ret_data,
    input issue_stall, ld_ret_ready, rf_we, rf_wa, rf_wd
  );
  modport slave (
    input issue_valid, issue_rs1, issue_rs2, issue_rd, issue_is_ld,
    input alu_wb_valid, alu_wb_rd, alu_wb_data,
    input ld_ret_valid, ld_ret_rd, ld_ret_data,
    output issue_stall, ld_ret_ready, rf_we, rf_wa, rf_wd
  );
endinterface

// File: rtl/rf_wb_scheduler_ld_ret_fifo.sv
// rf_wb_scheduler_ld_ret_fifo: sync {rd,data} FIFO (clk, rst_n async low, push/din, pop/dout, full, empty)
module rf_wb_scheduler_ld_ret_fifo
  import rf_wb_scheduler_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  ld_ret_t din,
  output ld_ret_t dout,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  ld_ret_t mem_q [DEPTH];
  ld_ret_t mem_d [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q[AW-1:0]] = din;
    wp_d = wp_q + {{AW{1'b0}}, push};
    rp_d = rp_q + {{AW{1'b0}}, pop};
    empty = wp_q == rp_q;
    full = wp_q == (rp_q ^ {1'b1, {AW{1'b0}}});
    dout = mem_q[rp_q[AW-1:0]];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: arbitrates the reg-file write port between ALU writeback and buffered load returns, stalling issue on hazards (clk, rst_n async low, bus slave)
module rf_wb_scheduler
  import rf_wb_scheduler_pkg::*;
#(
  parameter int LQ_DEPTH = 2,
  parameter int MAX_LOADS = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic clk,
  input logic rst_n,
  rf_wb_scheduler_if.slave bus
);
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  logic [31:0] pending_q, pending_d;
  logic [3:0] ld_cnt_q, ld_cnt_d;
  logic [AGE_W-1:0] age_q, age_d;
  ld_ret_t head;
  logic full, empty, push, pop, alu_win, starve, stall, ld_acc, ready;
  wsrc_e src;
  rf_wb_scheduler_ld_ret_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({bus.ld_ret_rd, bus.ld_ret_data}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  always_comb begin
    alu_win = bus.alu_wb_valid && bus.alu_wb_rd != '0;
    // an rd==0 head needs no port, so it retires even while the ALU writes
    pop = !empty && (!alu_win || head.rd == '0);
    src = alu_win ? WSRC_ALU : (!empty && head.rd != '0) ? WSRC_LD : WSRC_NONE;
    ready = rst_n && !full;
    push = bus.ld_ret_valid && ready;
    starve = age_q == AGE_W'(STARVE_LIMIT);
    stall = rst_n && bus.issue_valid && (pending_q[bus.issue_rs1] || pending_q[bus.issue_rs2] ||
            pending_q[bus.issue_rd] || (bus.issue_is_ld && ld_cnt_q == 4'(MAX_LOADS)) || starve);
    ld_acc = bus.issue_valid && !stall && bus.issue_is_ld;
    bus.issue_stall = stall;
    bus.ld_ret_ready = ready;
    bus.rf_we = rst_n && src != WSRC_NONE;
    bus.rf_wa = src == WSRC_ALU ? bus.alu_wb_rd : head.rd;
    bus.rf_wd = src == WSRC_ALU ? bus.alu_wb_data : head.data;
    pending_d = pending_q;
    if (pop) pending_d[head.rd] = 1'b0;
    if (ld_acc) pending_d[bus.issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
    ld_cnt_d = ld_cnt_q + 4'(ld_acc) - 4'(pop);
    age_d = (empty || pop) ? '0 : starve ? age_q : age_q + AGE_W'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      ld_cnt_q <= '0;
      age_q <= '0;
    end else begin
      pending_q <= pending_d;
      ld_cnt_q <= ld_cnt_d;
      age_q <= age_d;
    end
  end
  a_ret_pending: assert property (@(posedge clk) disable iff (!rst_n)
    push && bus.ld_ret_rd != '0 |-> pending_q[bus.ld_ret_rd]);
  a_cnt_under: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !ld_acc && ld_cnt_q == '0));
  a_cnt_over: assert property (@(posedge clk) disable iff (!rst_n)
    !(ld_acc && !pop && ld_cnt_q == 4'(MAX_LOADS)));
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb_rf_wb_scheduler: directed scenarios plus randomized traffic checked every cycle against a queue-based model
module tb_rf_wb_scheduler;
  localparam int LQ = 2;
  localparam int MAXL = 4;
  localparam int STARVE = 8;
  typedef struct {
    logic [4:0] rd;
    logic [31:0] d;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  rf_wb_scheduler_if bus ();
  rf_wb_scheduler #(.LQ_DEPTH(LQ), .MAX_LOADS(MAXL), .STARVE_LIMIT(STARVE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  int n_chk = 0;
  int n_fail = 0;
  logic rst_v, iv, isld, av, rv;
  logic [4:0] rs1, rs2, rd, ard, rrd;
  logic [31:0] adata, rdata;
  bit pend [32];
  int outstanding = 0;
  int waitc = 0;
  ent_t buf_q[$];
  logic [4:0] infl[$];
  logic e_pop, e_push, e_acc, m_rst;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic idle();
    iv = 0; rs1 = 0; rs2 = 0; rd = 0; isld = 0;
    av = 0; ard = 0; adata = 0;
    rv = 0; rrd = 0; rdata = 0;
  endtask
  task automatic compare();
    logic e_we, e_stall, e_ready, alu_w, have;
    logic [4:0] e_wa;
    logic [31:0] e_wd;
    e_we = 0; e_stall = 0; e_ready = 0; e_wa = 0; e_wd = 0;
    e_pop = 0; e_push = 0; e_acc = 0;
    m_rst = !rst_v;
    if (rst_v) begin
      have = buf_q.size() > 0;
      alu_w = av && ard != 0;
      e_ready = buf_q.size() < LQ;
      e_push = rv && e_ready;
      e_pop = have && (!alu_w || buf_q[0].rd == 0);
      if (alu_w) begin
        e_we = 1; e_wa = ard; e_wd = adata;
      end else if (have && buf_q[0].rd != 0) begin
        e_we = 1; e_wa = buf_q[0].rd; e_wd = buf_q[0].d;
      end
      e_stall = iv && (pend[rs1] || pend[rs2] || pend[rd] || (isld && outstanding == MAXL) || waitc >= STARVE);
      e_acc = iv && !e_stall && isld;
    end
    chk("model_stall", bus.issue_stall, e_stall);
    chk("model_ready", bus.ld_ret_ready, e_ready);
    chk("model_we", bus.rf_we, e_we);
    if (e_we) begin
      chk("model_wa", bus.rf_wa, e_wa);
      chk("model_wd", bus.rf_wd, e_wd);
    end
  endtask
  task automatic advance();
    ent_t h;
    int idx;
    if (m_rst) begin
      buf_q.delete();
      infl.delete();
      foreach (pend[i]) pend[i] = 0;
      outstanding = 0;
      waitc = 0;
      rv = 0;
    end else begin
      waitc = (buf_q.size() > 0 && !e_pop) ? ((waitc >= STARVE) ? STARVE : waitc + 1) : 0;
      if (e_pop) begin
        h = buf_q.pop_front();
        if (h.rd != 0) pend[h.rd] = 0;
        outstanding--;
      end
      if (e_acc) begin
        outstanding++;
        if (rd != 0) pend[rd] = 1;
        infl.push_back(rd);
      end
      if (e_push) begin
        buf_q.push_back('{rd: rrd, d: rdata});
        idx = -1;
        foreach (infl[i]) if (idx < 0 && infl[i] == rrd) idx = i;
        if (idx >= 0) infl.delete(idx);
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    rst_n = rst_v;
    bus.issue_valid = iv; bus.issue_rs1 = rs1; bus.issue_rs2 = rs2; bus.issue_rd = rd; bus.issue_is_ld = isld;
    bus.alu_wb_valid = av; bus.alu_wb_rd = ard; bus.alu_wb_data = adata;
    bus.ld_ret_valid = rv; bus.ld_ret_rd = rrd; bus.ld_ret_data = rdata;
    #1;
    compare();
    advance();
  endtask
  task automatic gen();
    iv = ($urandom % 4) != 0;
    rs1 = 5'($urandom % 8); rs2 = 5'($urandom % 8); rd = 5'($urandom % 8);
    isld = ($urandom % 3) == 0;
    av = ($urandom % 10) < 6;
    ard = 5'($urandom % 16);
    adata = $urandom;
    if (!(rv && !e_push)) begin
      rv = 0;
      if (infl.size() > 0 && ($urandom % 3) == 0) begin
        rrd = infl[$urandom % infl.size()];
        rdata = $urandom;
        rv = 1;
      end
    end
  endtask
  initial begin
    e_push = 0;
    idle();
    rst_v = 0; iv = 1; rd = 4; av = 1; ard = 3; adata = 32'h33;
    step();
    chk("rst_we", bus.rf_we, 0);
    chk("rst_stall", bus.issue_stall, 0);
    chk("rst_ready", bus.ld_ret_ready, 0);
    idle(); rst_v = 1;
    step();
    chk("post_rst_ready", bus.ld_ret_ready, 1);
    // load x5, dependent add stalls until the cycle after commit
    iv = 1; isld = 1; rd = 5;
    step();
    chk("s1_ld_accept", bus.issue_stall, 0);
    isld = 0; rs1 = 5; rd = 6;
    step();
    chk("s1_raw_stall", bus.issue_stall, 1);
    step();
    rv = 1; rrd = 5; rdata = 32'hA5A50005;
    step();
    chk("s1_ret_ready", bus.ld_ret_ready, 1);
    rv = 0;
    step();
    chk("s1_we", bus.rf_we, 1);
    chk("s1_wa", bus.rf_wa, 5);
    chk("s1_wd", bus.rf_wd, 32'hA5A50005);
    chk("s1_stall_commit", bus.issue_stall, 1);
    step();
    chk("s1_stall_drop", bus.issue_stall, 0);
    // load to x0 retires alongside an ALU write
    idle(); iv = 1; isld = 1; rd = 0;
    step();
    idle(); rv = 1; rrd = 0; rdata = 32'h123;
    step();
    idle(); av = 1; ard = 9; adata = 32'h9999;
    step();
    chk("s4_wa", bus.rf_wa, 9);
    chk("s4_wd", bus.rf_wd, 32'h9999);
    idle();
    step();
    chk("s4_head_gone", bus.rf_we, 0);
    // outstanding-load limit
    idle(); iv = 1; isld = 1;
    for (int k = 0; k < 4; k++) begin
      rd = 5'(10 + k);
      step();
      chk("s3_ld_accept", bus.issue_stall, 0);
    end
    rd = 14;
    step();
    chk("s3_limit_stall", bus.issue_stall, 1);
    rv = 1; rrd = 10; rdata = 32'h1010;
    step();
    rv = 0;
    step();
    chk("s3_commit_wa", bus.rf_wa, 10);
    chk("s3_commit_stall", bus.issue_stall, 1);
    step();
    chk("s3_fifth_accept", bus.issue_stall, 0);
    idle();
    for (int k = 11; k < 15; k++) begin
      rv = 1; rrd = 5'(k); rdata = 32'(k);
      step();
    end
    idle();
    for (int k = 0; k < 3; k++) step();
    // starvation under continuous ALU writeback
    idle(); iv = 1; isld = 1; rd = 3;
    step();
    idle(); av = 1; ard = 7; adata = 32'h7777; rv = 1; rrd = 3; rdata = 32'h3333;
    step();
    chk("s2_alu_wa", bus.rf_wa, 7);
    rv = 0; iv = 1; rs1 = 1; rd = 2;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("s2_no_starve", bus.issue_stall, 0);
    end
    step();
    chk("s2_starve", bus.issue_stall, 1);
    chk("s2_alu_prio", bus.rf_wa, 7);
    av = 0;
    step();
    chk("s2_drain_wa", bus.rf_wa, 3);
    chk("s2_drain_wd", bus.rf_wd, 32'h3333);
    chk("s2_drain_stall", bus.issue_stall, 1);
    step();
    chk("s2_stall_drop", bus.issue_stall, 0);
    // buffer fills under ALU traffic, third return waits
    idle(); iv = 1; isld = 1;
    for (int k = 20; k < 23; k++) begin
      rd = 5'(k);
      step();
    end
    idle(); av = 1; ard = 7; rv = 1; rrd = 20; rdata = 32'h20;
    step();
    chk("s5_ready0", bus.ld_ret_ready, 1);
    rrd = 21; rdata = 32'h21;
    step();
    chk("s5_ready1", bus.ld_ret_ready, 1);
    rrd = 22; rdata = 32'h22;
    step();
    chk("s5_full", bus.ld_ret_ready, 0);
    av = 0;
    step();
    chk("s5_full_pop", bus.ld_ret_ready, 0);
    chk("s5_wa20", bus.rf_wa, 20);
    step();
    chk("s5_ready_again", bus.ld_ret_ready, 1);
    chk("s5_wa21", bus.rf_wa, 21);
    rv = 0;
    step();
    chk("s5_wa22", bus.rf_wa, 22);
    step();
    chk("s5_idle", bus.rf_we, 0);
    // reset mid-operation with a full buffer
    idle(); iv = 1; isld = 1; rd = 24;
    step();
    rd = 25;
    step();
    idle(); av = 1; ard = 7; rv = 1; rrd = 24;
    step();
    rrd = 25;
    step();
    rv = 0; rst_v = 0; iv = 1; rs1 = 24; rd = 26;
    step();
    chk("s6_rst_we", bus.rf_we, 0);
    chk("s6_rst_stall", bus.issue_stall, 0);
    chk("s6_rst_ready", bus.ld_ret_ready, 0);
    rst_v = 1; av = 0;
    step();
    chk("s6_ready", bus.ld_ret_ready, 1);
    chk("s6_no_pend", bus.issue_stall, 0);
    chk("s6_no_stale", bus.rf_we, 0);
    idle();
    step();
    chk("s6_no_stale2", bus.rf_we, 0);
    for (int c = 0; c < 3000; c++) begin
      rst_v = !(c >= 1500 && c < 1503);
      gen();
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
